tile_row_drawer: RTL
====================

TILE_ROW_DRAWER -- requirements
Module: tile_row_drawer

Interface
REQ-001 SHALL have these ports, clock and reset first: clock  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have reset  in  1; one clock, reset synchronous and active-high.
REQ-003 SHALL have draw_go  in  1; level request from the game controller, held high until draw_done is seen.
REQ-004 SHALL have offset  in  6; index of the band to draw, valid range 0..39.
REQ-005 SHALL have tile_pattern  in  4; bit i=1 means lane i holds a black tile in this band.
REQ-006 SHALL have x  out  8; pixel column, 0..159.
REQ-007 SHALL have y  out  7; pixel row, 0..119.
REQ-008 SHALL have colour  out  3; pixel colour to the VGA adapter.
REQ-009 SHALL have plot  out  1; write strobe, one pixel per high cycle.
REQ-010 SHALL have draw_done  out  1; band complete, held high until draw_go falls.

Function
REQ-011 Geometry SHALL be: screen 160x120, 4 lanes of 40 px, lane i = x 40i..40i+39, bands of 3 lines, band b = y 3b..3b+2.
REQ-012 FSM SHALL have states IDLE, DRAW and DONE.
REQ-013 IDLE: if draw_go=1 and offset<=39, SHALL latch offset and tile_pattern, set x=0 and y=3*offset, and go to DRAW.
REQ-014 IDLE: if draw_go=1 and offset>=40, SHALL go to DONE with no pixel plotted.
REQ-015 DRAW: plot=1 every cycle.
REQ-016 DRAW: x SHALL increment each cycle; at x=159, x wraps to 0 and y increments.
REQ-017 DRAW: after pixel (159, 3*offset+2), SHALL go to DONE.
REQ-018 Colour SHALL be 3'b001 (divider) when x mod 40 = 0, else 3'b000 if the latched lane bit is 1, else 3'b111.
REQ-019 Timing: draw_go sampled high in IDLE at edge N gives the first plot in cycle N+1, exactly 480 consecutive plot cycles, and draw_done=1 from cycle N+481.
REQ-020 DONE: draw_done=1 and plot=0; SHALL return to IDLE on the first cycle draw_go=0.
REQ-021 draw_go falling during DRAW SHALL abort to IDLE next edge: plot=0, no draw_done pulse.
REQ-022 Input changes to offset or tile_pattern during DRAW or DONE SHALL be ignored (latched values used).
REQ-023 Outputs SHALL be registered, and x, y and colour SHALL be valid whenever plot=1.
REQ-024 x and y SHALL never leave 0..159 and 0..119.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE with plot=0, draw_done=0, x=0, y=0, colour=3'b000, latches cleared.
REQ-026 Reset SHALL take priority over draw_go, including mid-DRAW: no further pixels plotted after the reset edge.
REQ-027 After reset deasserts, a still-high draw_go SHALL start a fresh band per REQ-013.

Structure
REQ-028 A shared package SHALL hold: SCREEN_W=160, SCREEN_H=120, LANE_W=40, BAND_H=3, NUM_BANDS=40, colours COL_BLACK/COL_WHITE/COL_DIVIDER, and the FSM state encoding.
REQ-029 One sub-module, band_pixel_counter (x/y stepping with last-pixel flag), SHALL be used.
REQ-030 The rest (FSM, latches, colour mux) SHALL stay in the top level.

Verification
REQ-031 offset=0, pattern=4'b0101, draw_go held -> 480 plots over y 0..2; black at x 1..39 and 81..119; white at 41..79 and 121..159; divider at x=0,40,80,120; draw_done at cycle 481.
REQ-032 offset=39, pattern=4'b1111 -> y spans 117..119; last plot (159,119); no out-of-range coordinate.
REQ-033 offset=45 -> zero plots; draw_done high the cycle after the request; IDLE once draw_go drops.
REQ-034 draw_go dropped after 100 plots -> plot low the next cycle; no draw_done; new request at offset=5 restarts at (0,15).
REQ-035 reset pulsed at plot 200 -> all outputs at reset values next cycle; after release, held draw_go restarts from x=0.
REQ-036 pattern changed from 4'b0001 to 4'b1000 mid-DRAW -> colours still follow 4'b0001 for the whole band.

Source files
------------

// File: rtl/tile_row_drawer_pkg.sv
// Shared geometry, colour codes and FSM encoding for the tile row drawer.
// A band is BAND_H full-width lines; the screen holds NUM_BANDS of them.
package tile_row_drawer_pkg;

  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;
  localparam int unsigned LANE_W    = 40;
  localparam int unsigned BAND_H    = 3;
  localparam int unsigned NUM_BANDS = 40;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_WHITE   = 3'b111;
  localparam logic [2:0] COL_DIVIDER = 3'b001;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDraw = 2'd1,
    StDone = 2'd2
  } state_e;

  // First line of a band: 3 * band index, done as shift-and-add.
  function automatic logic [6:0] band_y(input logic [5:0] band);
    logic [6:0] b7;
    b7 = {1'b0, band};
    return (b7 << 1) + b7;
  endfunction

endpackage

// File: rtl/band_pixel_counter.sv
// Walks x across the screen and y down the band; flags the final pixel.
// Loading takes priority over stepping; stepping is suppressed on the last pixel.
module band_pixel_counter
  import tile_row_drawer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [6:0] y_start_i,
  input  logic [6:0] y_last_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic [7:0] x_next_o,
  output logic       last_o
);

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       x_end;

  assign x_end  = (x_q == 8'(SCREEN_W - 1));
  assign last_o = x_end && (y_q == y_last_i);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = 8'd0;
      y_d = y_start_i;
    end else if (step_i && !last_o) begin
      if (x_end) begin
        x_d = 8'd0;
        y_d = y_q + 7'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= 8'd0;
      y_q <= 7'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign x_next_o = x_d;

endmodule

// File: rtl/tile_row_drawer.sv
// Draws one 160x3 band of lane tiles, one registered pixel per cycle.
// Handshake: draw_go is a level request; draw_done holds until draw_go falls.
module tile_row_drawer
  import tile_row_drawer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       draw_go,
  input  logic [5:0] offset,
  input  logic [3:0] tile_pattern,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       draw_done
);

  state_e     state_q, state_d;
  logic [3:0] pattern_q, pattern_d;
  logic [5:0] offset_q, offset_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;
  logic       cnt_load, cnt_step, cnt_last;
  logic [7:0] x_next;

  // Divider on each lane's first column, otherwise the lane's tile colour.
  function automatic logic [2:0] lane_colour(input logic [7:0] px, input logic [3:0] pat);
    logic [1:0] lane;
    logic [7:0] base;
    if (px < 8'(LANE_W)) begin
      lane = 2'd0;
      base = 8'd0;
    end else if (px < 8'(2 * LANE_W)) begin
      lane = 2'd1;
      base = 8'(LANE_W);
    end else if (px < 8'(3 * LANE_W)) begin
      lane = 2'd2;
      base = 8'(2 * LANE_W);
    end else begin
      lane = 2'd3;
      base = 8'(3 * LANE_W);
    end
    if (px == base) return COL_DIVIDER;
    return pat[lane] ? COL_BLACK : COL_WHITE;
  endfunction

  band_pixel_counter u_counter (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (cnt_load),
    .step_i    (cnt_step),
    .y_start_i (band_y(offset)),
    .y_last_i  (band_y(offset_q) + 7'(BAND_H - 1)),
    .x_o       (x),
    .y_o       (y),
    .x_next_o  (x_next),
    .last_o    (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    offset_d  = offset_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    done_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_step  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (draw_go) begin
          if (offset <= 6'(NUM_BANDS - 1)) begin
            state_d   = StDraw;
            pattern_d = tile_pattern;
            offset_d  = offset;
            cnt_load  = 1'b1;
            plot_d    = 1'b1;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDraw: begin
        if (!draw_go) begin
          state_d = StIdle;
        end else if (cnt_last) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cnt_step = 1'b1;
          plot_d   = 1'b1;
        end
      end
      StDone: begin
        if (draw_go) begin
          done_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Colour tracks the pixel the counter will present next cycle.
    if (plot_d) begin
      colour_d = lane_colour(x_next, pattern_d);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pattern_q <= 4'd0;
      offset_q  <= 6'd0;
      colour_q  <= COL_BLACK;
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      offset_q  <= offset_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      done_q    <= done_d;
    end
  end

  assign colour    = colour_q;
  assign plot      = plot_q;
  assign draw_done = done_q;

endmodule
